// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes an RV32I ALU instruction, selects the operands and issues a registered,
// flow-controlled bundle to the execute stage.
//
// Ports:
//   i_Clock, i_Reset (synchronous, active low)
//   upstream   : i_Valid / o_Ready, i_Instruction, i_Pc, i_Rs1_Data, i_Rs2_Data
//   downstream : o_Valid / i_Ready, o_Alu_Select, o_Input_A, o_Input_B, o_Rd, o_Reg_Write,
//                o_Illegal
//
// A two-entry skid buffer (output register plus one skid register) keeps o_Ready registered
// while still sustaining one bundle per cycle.
module alu_issue_stage #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    input  logic                      i_Valid,
    output logic                      o_Ready,
    input  logic [31:0]               i_Instruction,
    input  logic [XLEN-1:0]           i_Pc,
    input  logic [XLEN-1:0]           i_Rs1_Data,
    input  logic [XLEN-1:0]           i_Rs2_Data,
    output logic                      o_Valid,
    input  logic                      i_Ready,
    output logic [3:0]                o_Alu_Select,
    output logic [XLEN-1:0]           o_Input_A,
    output logic [XLEN-1:0]           o_Input_B,
    output logic [REG_ADDR_WIDTH-1:0] o_Rd,
    output logic                      o_Reg_Write,
    output logic                      o_Illegal
);

    localparam logic [3:0] AluAdd     = 4'd0;
    localparam logic [3:0] AluSub     = 4'd1;
    localparam logic [3:0] AluAnd     = 4'd2;
    localparam logic [3:0] AluOr      = 4'd3;
    localparam logic [3:0] AluXor     = 4'd4;
    localparam logic [3:0] AluSll     = 4'd5;
    localparam logic [3:0] AluSrl     = 4'd6;
    localparam logic [3:0] AluSra     = 4'd7;
    localparam logic [3:0] AluUnknown = 4'd15;

    localparam logic [6:0] OpcodeOp    = 7'b0110011;
    localparam logic [6:0] OpcodeOpImm = 7'b0010011;
    localparam logic [6:0] OpcodeLui   = 7'b0110111;
    localparam logic [6:0] OpcodeAuipc = 7'b0010111;

    localparam logic [6:0] Funct7Base = 7'b0000000;
    localparam logic [6:0] Funct7Alt  = 7'b0100000;

    typedef struct packed {
        logic [3:0]                sel;
        logic [XLEN-1:0]           a;
        logic [XLEN-1:0]           b;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write;
        logic                      illegal;
    } bundle_t;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic [6:0]                funct7;
    logic [REG_ADDR_WIDTH-1:0] rd_idx;
    logic [REG_ADDR_WIDTH-1:0] shamt;
    logic [XLEN-1:0]           imm_i;
    logic [XLEN-1:0]           imm_u;
    logic [XLEN-1:0]           imm_shamt;
    logic                      legal;
    bundle_t                   dec;

    // The rs1 index field is consumed by the register file, not here.
    logic unused_rs1_idx;
    assign unused_rs1_idx = ^i_Instruction[19:15];

    assign opcode    = i_Instruction[6:0];
    assign funct3    = i_Instruction[14:12];
    assign funct7    = i_Instruction[31:25];
    assign rd_idx    = i_Instruction[7 +: REG_ADDR_WIDTH];
    assign shamt     = i_Instruction[20 +: REG_ADDR_WIDTH];
    assign imm_i     = XLEN'($signed(i_Instruction[31:20]));
    assign imm_u     = XLEN'($signed({i_Instruction[31:12], 12'b0}));
    assign imm_shamt = XLEN'(shamt);

    always_comb begin
        dec       = '0;
        dec.sel   = AluUnknown;
        dec.rd    = rd_idx;
        legal     = 1'b0;

        case (opcode)
            OpcodeOp: begin
                dec.a = i_Rs1_Data;
                dec.b = i_Rs2_Data;
                case (funct3)
                    3'b000: begin
                        if (funct7 == Funct7Base) begin
                            dec.sel = AluAdd;
                            legal   = 1'b1;
                        end else if (funct7 == Funct7Alt) begin
                            dec.sel = AluSub;
                            legal   = 1'b1;
                        end
                    end
                    3'b001: begin
                        dec.sel = AluSll;
                        legal   = (funct7 == Funct7Base);
                    end
                    3'b100: begin
                        dec.sel = AluXor;
                        legal   = (funct7 == Funct7Base);
                    end
                    3'b110: begin
                        dec.sel = AluOr;
                        legal   = (funct7 == Funct7Base);
                    end
                    3'b111: begin
                        dec.sel = AluAnd;
                        legal   = (funct7 == Funct7Base);
                    end
                    3'b101: begin
                        if (funct7 == Funct7Base) begin
                            dec.sel = AluSrl;
                            legal   = 1'b1;
                        end else if (funct7 == Funct7Alt) begin
                            dec.sel = AluSra;
                            legal   = 1'b1;
                        end
                    end
                    default: legal = 1'b0; // SLT/SLTU have no ALU op
                endcase
            end
            OpcodeOpImm: begin
                dec.a = i_Rs1_Data;
                dec.b = imm_i;
                case (funct3)
                    3'b000: begin
                        dec.sel = AluAdd;
                        legal   = 1'b1;
                    end
                    3'b100: begin
                        dec.sel = AluXor;
                        legal   = 1'b1;
                    end
                    3'b110: begin
                        dec.sel = AluOr;
                        legal   = 1'b1;
                    end
                    3'b111: begin
                        dec.sel = AluAnd;
                        legal   = 1'b1;
                    end
                    3'b001: begin
                        dec.sel = AluSll;
                        dec.b   = imm_shamt;
                        legal   = (funct7 == Funct7Base);
                    end
                    3'b101: begin
                        dec.b = imm_shamt;
                        if (funct7 == Funct7Base) begin
                            dec.sel = AluSrl;
                            legal   = 1'b1;
                        end else if (funct7 == Funct7Alt) begin
                            dec.sel = AluSra;
                            legal   = 1'b1;
                        end
                    end
                    default: legal = 1'b0;
                endcase
            end
            OpcodeLui: begin
                dec.sel = AluAdd;
                dec.a   = '0;
                dec.b   = imm_u;
                legal   = 1'b1;
            end
            OpcodeAuipc: begin
                dec.sel = AluAdd;
                dec.a   = i_Pc;
                dec.b   = imm_u;
                legal   = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        // Illegal bundles still issue so the trap logic sees them, but carry no operands.
        if (!legal) begin
            dec.sel = AluUnknown;
            dec.a   = '0;
            dec.b   = '0;
        end
        dec.illegal   = !legal;
        dec.reg_write = legal && (rd_idx != '0);
    end

    // ------------------------------------------------------------------
    // Output register + skid register
    // ------------------------------------------------------------------
    bundle_t out_q, out_d;
    bundle_t skid_q, skid_d;
    logic    out_valid_q, out_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    ready_q, ready_d;
    logic    accept;
    logic    consume;

    assign accept  = i_Valid && ready_q;
    assign consume = out_valid_q && i_Ready;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        if (consume) begin
            // ready_q is low whenever skid is full, so accept cannot coincide with a skid drain.
            if (skid_valid_q) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d = dec;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end
        end

        ready_d = !skid_valid_d;
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign o_Ready      = ready_q;
    assign o_Valid      = out_valid_q;
    assign o_Alu_Select = out_q.sel;
    assign o_Input_A    = out_q.a;
    assign o_Input_B    = out_q.b;
    assign o_Rd         = out_q.rd;
    assign o_Reg_Write  = out_q.reg_write;
    assign o_Illegal    = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(
        .XLEN           (32),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .i_Clock       (clk),
        .i_Reset       (rst_n),
        .i_Valid       (in_valid),
        .o_Ready       (in_ready),
        .i_Instruction (instr),
        .i_Pc          (pc),
        .i_Rs1_Data    (rs1),
        .i_Rs2_Data    (rs2),
        .o_Valid       (out_valid),
        .i_Ready       (out_ready),
        .o_Alu_Select  (alu_sel),
        .o_Input_A     (op_a),
        .o_Input_B     (op_b),
        .o_Rd          (rd),
        .o_Reg_Write   (reg_write),
        .o_Illegal     (illegal)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bundle(input string tag, input logic [3:0] e_sel, input logic [31:0] e_a,
                                input logic [31:0] e_b, input logic [4:0] e_rd,
                                input logic e_rw, input logic e_ill);
        check_eq({tag, ".valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, ".sel"}, 32'(alu_sel), 32'(e_sel));
        check_eq({tag, ".a"}, op_a, e_a);
        check_eq({tag, ".b"}, op_b, e_b);
        check_eq({tag, ".rd"}, 32'(rd), 32'(e_rd));
        check_eq({tag, ".rw"}, 32'(reg_write), 32'(e_rw));
        check_eq({tag, ".ill"}, 32'(illegal), 32'(e_ill));
    endtask

    // Advance one rising edge; outputs are then stable for sampling and inputs may change.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i_w, input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] b);
        in_valid = 1'b1;
        instr    = i_w;
        pc       = p;
        rs1      = a;
        rs2      = b;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = '0;
        pc        = '0;
        rs1       = '0;
        rs2       = '0;

        // Reset held for two edges
        step();
        step();
        check_eq("rst.valid", 32'(out_valid), 32'd0);
        check_eq("rst.ready", 32'(in_ready), 32'd0);
        check_eq("rst.sel", 32'(alu_sel), 32'd0);
        check_eq("rst.a", op_a, 32'd0);
        check_eq("rst.b", op_b, 32'd0);
        check_eq("rst.rd", 32'(rd), 32'd0);
        check_eq("rst.rw", 32'(reg_write), 32'd0);
        check_eq("rst.ill", 32'(illegal), 32'd0);
        rst_n = 1'b1;
        step();
        check_eq("rel.ready", 32'(in_ready), 32'd1);
        check_eq("rel.valid", 32'(out_valid), 32'd0);

        // Back-to-back stream with i_Ready=1
        out_ready = 1'b1;
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7);             // add x3,x1,x2
        step();
        check_bundle("add", 4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
        drive(32'h402081B3, 32'h0, 32'd5, 32'd7);             // sub x3,x1,x2
        step();
        check_bundle("sub", 4'd1, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
        drive(32'h4040D293, 32'h0, 32'hF000_0000, 32'd9);     // srai x5,x1,4
        step();
        check_bundle("srai", 4'd7, 32'hF000_0000, 32'd4, 5'd5, 1'b1, 1'b0);
        drive(32'h12345097, 32'h100, 32'd1, 32'd2);           // auipc x1,0x12345
        step();
        check_bundle("auipc", 4'd0, 32'h100, 32'h1234_5000, 5'd1, 1'b1, 1'b0);
        drive(32'h00001037, 32'h0, 32'd3, 32'd4);             // lui x0,1
        step();
        check_bundle("lui", 4'd0, 32'd0, 32'h0000_1000, 5'd0, 1'b0, 1'b0);
        drive(32'hFFF08393, 32'h0, 32'd10, 32'd0);            // addi x7,x1,-1
        step();
        check_bundle("addi", 4'd0, 32'd10, 32'hFFFF_FFFF, 5'd7, 1'b1, 1'b0);
        in_valid = 1'b0;
        step();
        check_eq("drain.valid", 32'(out_valid), 32'd0);

        // Stall: three bundles against i_Ready=0
        out_ready = 1'b0;
        drive(32'h002081B3, 32'h0, 32'd11, 32'd12);           // add x3
        step();
        check_bundle("st1", 4'd0, 32'd11, 32'd12, 5'd3, 1'b1, 1'b0);
        check_eq("st1.ready", 32'(in_ready), 32'd1);
        drive(32'h0020C233, 32'h0, 32'd21, 32'd22);           // xor x4
        step();
        check_eq("st2.ready", 32'(in_ready), 32'd0);
        check_bundle("st2.hold", 4'd0, 32'd11, 32'd12, 5'd3, 1'b1, 1'b0);
        drive(32'h0020E333, 32'h0, 32'd31, 32'd32);           // or x6
        step();
        step();
        check_eq("st3.ready", 32'(in_ready), 32'd0);
        check_bundle("st3.hold", 4'd0, 32'd11, 32'd12, 5'd3, 1'b1, 1'b0);
        out_ready = 1'b1;
        step();                                               // b1 out, skid b2 to output
        check_bundle("st.b2", 4'd4, 32'd21, 32'd22, 5'd4, 1'b1, 1'b0);
        check_eq("st.b2.ready", 32'(in_ready), 32'd1);
        step();                                               // b2 out, b3 accepted
        check_bundle("st.b3", 4'd3, 32'd31, 32'd32, 5'd6, 1'b1, 1'b0);
        in_valid = 1'b0;
        step();
        check_eq("st.drain", 32'(out_valid), 32'd0);

        // Illegal encodings
        drive(32'h0020A1B3, 32'h0, 32'd5, 32'd7);             // slt x3,x1,x2
        step();
        check_bundle("slt", 4'd15, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1);
        drive(32'h0000007F, 32'h40, 32'd5, 32'd7);            // unknown opcode
        step();
        check_bundle("opc7f", 4'd15, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
        drive(32'h4020C1B3, 32'h0, 32'd5, 32'd7);             // xor with funct7 0100000
        step();
        check_bundle("badf7", 4'd15, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1);
        in_valid = 1'b0;
        step();

        // Reset with output and skid both full
        out_ready = 1'b0;
        drive(32'h002081B3, 32'h0, 32'd1, 32'd2);
        step();
        drive(32'h402081B3, 32'h0, 32'd3, 32'd4);
        step();
        check_eq("mid.ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        check_eq("mid.rst.valid", 32'(out_valid), 32'd0);
        check_eq("mid.rst.ready", 32'(in_ready), 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        check_eq("mid.rel.ready", 32'(in_ready), 32'd1);
        check_eq("mid.rel.valid", 32'(out_valid), 32'd0);
        step();
        step();
        check_eq("mid.idle.valid", 32'(out_valid), 32'd0);
        drive(32'h0020F1B3, 32'h0, 32'h0F0F, 32'h00FF);       // and x3,x1,x2
        step();
        check_bundle("mid.new", 4'd2, 32'h0F0F, 32'h00FF, 5'd3, 1'b1, 1'b0);
        in_valid = 1'b0;
        step();
        check_eq("end.valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
